moore_residue: RTL and testbench

Parametrised Moore residue detector, the next generation of our fixed 2-bit Moore lab machine. It accumulates qualified input samples modulo `MOD` and asserts `aout` whenever the running residue is zero. Two accumulation modes are supported: sum of sample values, or sum of set bits. It also keeps a saturating count of zero-residue hits. It sits directly on the sampled input path and feeds the board LED/status logic.

---
 rtl/moore_pkg.sv | 24 ++
 rtl/moore_popcount.sv | 25 ++
 rtl/moore_residue.sv | 91 +++++++++
 tb/tb_moore_residue.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/moore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : moore_pkg
//  Description : Shared constants and width helpers for the Moore residue
//                detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package moore_pkg;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_ONES = 1'b1;

    // Bits needed to hold a popcount of a w-bit vector (0..w).
    function automatic int popcount_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Residue register width; a 1-bit floor keeps tiny moduli legal.
    function automatic int res_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/moore_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : moore_popcount
//  Description : Combinational count of set bits in an IN_W-bit sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore_popcount
    import moore_pkg::*;
#(
    parameter int IN_W = 2,
    parameter int PC_W = popcount_width(IN_W)
) (
    input  logic [IN_W-1:0] ain,
    output logic [PC_W-1:0] ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < IN_W; i++) begin
            ones = ones + PC_W'(ain[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/moore_residue.sv
`default_nettype none
// ============================================================================
//  Module      : moore_residue
//  Description : Moore detector accumulating qualified samples modulo MOD,
//                flagging zero residue and counting zero-residue hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore_residue
    import moore_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int MOD   = 3,
    parameter int CNT_W = 8,
    parameter int RES_W = res_width(MOD)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  ain,
    input  logic             valid,
    input  logic             mode,
    input  logic             clear,
    output logic             aout,
    output logic [RES_W-1:0] residue,
    output logic [CNT_W-1:0] hit_count
);

    localparam int PC_W  = popcount_width(IN_W);
    localparam int SUM_W = ((RES_W > IN_W) ? RES_W : IN_W) + 1;
    localparam logic [SUM_W-1:0] c_mod    = SUM_W'(MOD);
    localparam logic [CNT_W-1:0] c_hc_max = '1;

    logic [RES_W-1:0] r_res;
    logic [CNT_W-1:0] r_hc;
    logic [PC_W-1:0]  w_ones;
    logic [SUM_W-1:0] w_raw;
    logic [SUM_W-1:0] w_contrib;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_red;
    logic [RES_W-1:0] w_res_step;
    logic [RES_W-1:0] w_next_res;
    logic [CNT_W-1:0] w_next_hc;

    moore_popcount #(
        .IN_W (IN_W),
        .PC_W (PC_W)
    ) u_popcount (
        .ain  (ain),
        .ones (w_ones)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_res <= '0;
            r_hc  <= '0;
        end else begin
            r_res <= w_next_res;
            r_hc  <= w_next_hc;
        end
    end

    // Next state: both operands are already below MOD after the first
    // reduction, so a single conditional subtract finishes the modulo.
    always_comb begin
        w_raw      = (mode == MODE_ONES) ? SUM_W'(w_ones) : SUM_W'(ain);
        w_contrib  = w_raw % c_mod;
        w_sum      = SUM_W'(r_res) + w_contrib;
        w_red      = (w_sum >= c_mod) ? (w_sum - c_mod) : w_sum;
        w_res_step = RES_W'(w_red);
        w_next_res = r_res;
        w_next_hc  = r_hc;
        if (clear) begin
            w_next_res = '0;
            w_next_hc  = '0;
        end else if (valid) begin
            w_next_res = w_res_step;
            if ((w_res_step == '0) && (r_hc != c_hc_max)) begin
                w_next_hc = r_hc + 1'b1;
            end
        end
    end

    // Outputs depend on state only.
    always_comb begin
        aout      = (r_res == '0);
        residue   = r_res;
        hit_count = r_hc;
    end

endmodule
`default_nettype wire

// File: tb/tb_moore_residue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore_residue
//  Description : Self-checking bench for moore_residue against an arithmetic
//                reference model, three parameter sets in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_residue;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] ain;
    logic [3:0] ain4;
    logic       valid, mode, clear;

    logic       aout0, aout1, aout2;
    logic [1:0] res0, res1;
    logic [2:0] res2;
    logic [7:0] hc0, hc2;
    logic [1:0] hc1;

    int checks   = 0;
    int failures = 0;

    int c_mod [3] = '{3, 3, 5};
    int c_hmax[3] = '{255, 3, 255};
    int m_res [3];
    int m_hc  [3];

    always #5 clock = ~clock;

    moore_residue #(.IN_W(2), .MOD(3), .CNT_W(8)) u_dut0 (
        .clock(clock), .reset(reset), .ain(ain), .valid(valid), .mode(mode),
        .clear(clear), .aout(aout0), .residue(res0), .hit_count(hc0));

    moore_residue #(.IN_W(2), .MOD(3), .CNT_W(2)) u_dut1 (
        .clock(clock), .reset(reset), .ain(ain), .valid(valid), .mode(mode),
        .clear(clear), .aout(aout1), .residue(res1), .hit_count(hc1));

    moore_residue #(.IN_W(4), .MOD(5), .CNT_W(8)) u_dut2 (
        .clock(clock), .reset(reset), .ain(ain4), .valid(valid), .mode(mode),
        .clear(clear), .aout(aout2), .residue(res2), .hit_count(hc2));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_res[k] = 0;
            m_hc[k]  = 0;
        end
    endtask

    // Reference: running sum of contributions modulo MOD, saturating hits.
    task automatic model_edge();
        int a, c;
        for (int k = 0; k < 3; k++) begin
            a = (k == 2) ? int'(ain4) : int'(ain);
            if (clear) begin
                m_res[k] = 0;
                m_hc[k]  = 0;
            end else if (valid) begin
                c = mode ? $countones(a) : a;
                m_res[k] = (m_res[k] + c) % c_mod[k];
                if (m_res[k] == 0 && m_hc[k] < c_hmax[k]) m_hc[k]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".res0"},  int'(res0),  m_res[0]);
        check({tag, ".aout0"}, int'(aout0), int'(m_res[0] == 0));
        check({tag, ".hc0"},   int'(hc0),   m_hc[0]);
        check({tag, ".res1"},  int'(res1),  m_res[1]);
        check({tag, ".aout1"}, int'(aout1), int'(m_res[1] == 0));
        check({tag, ".hc1"},   int'(hc1),   m_hc[1]);
        check({tag, ".res2"},  int'(res2),  m_res[2]);
        check({tag, ".aout2"}, int'(aout2), int'(m_res[2] == 0));
        check({tag, ".hc2"},   int'(hc2),   m_hc[2]);
    endtask

    task automatic step(input string tag, input logic [1:0] a, input logic [3:0] a4,
                        input logic v, input logic md, input logic clr);
        ain = a; ain4 = a4; valid = v; mode = md; clear = clr;
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; ain = 2'b11; ain4 = 4'hF; valid = 1'b1; mode = 1'b0; clear = 1'b0;
        model_reset();
        #2  check_all("rst_a");
        #6  check_all("rst_b");
        #4  reset = 1'b1;

        // Already at zero: holding at zero still counts hits.
        for (int i = 0; i < 3; i++) step("s1", 2'b11, 4'h0, 1'b1, 1'b0, 1'b0);
        check("s1.hc_direct", int'(hc0), 3);

        for (int i = 0; i < 3; i++) step("s2", 2'b01, 4'h1, 1'b1, 1'b0, 1'b0);
        check("s2.res_direct", int'(res0), 0);

        for (int i = 0; i < 3; i++) step("s3", 2'b11, 4'h3, 1'b1, 1'b1, 1'b0);
        step("s3b", 2'b10, 4'h2, 1'b1, 1'b1, 1'b0);
        check("s3.res_direct", int'(res0), 1);

        for (int i = 0; i < 5; i++)
            step("s4", 2'($urandom), 4'($urandom), 1'b0, 1'($urandom), 1'b0);

        step("s5a", 2'b01, 4'h1, 1'b1, 1'b0, 1'b0);
        check("s5.res_pre", int'(res0), 2);
        step("s5clr", 2'b01, 4'h1, 1'b1, 1'b0, 1'b1);
        step("s5b", 2'b01, 4'h3, 1'b1, 1'b0, 1'b0);
        step("s5c", 2'b10, 4'h6, 1'b1, 1'b1, 1'b0);
        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("s5rst");
        @(posedge clock);
        #1 check_all("s5rst_edge");
        #2 reset = 1'b1;

        step("s6clr", 2'b00, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("s6", 2'b00, 4'hF, 1'b1, 1'b0, 1'b0);
        check("s6.hc1_sat", int'(hc1), 3);
        check("s6.hc2_hits", int'(hc2), 5);

        for (int i = 0; i < 300; i++)
            step("rnd", 2'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom_range(0, 19) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
